count_schedule_ctrl: RTL and testbench

Controller that sequences a shrinking-limit up-counter through a programmable schedule of round limits. Each round counts 0..limit; after each round the limit drops by a step until it falls below a floor. At that point the block either finishes or reloads and repeats. It sits between a host/config interface (start/abort/config) and the counter datapath, and owns all limit sequencing.

---
 rtl/count_sched_pkg.sv | 21 ++
 rtl/limit_counter.sv | 30 +++
 rtl/count_schedule_ctrl.sv | 140 ++++++++++++++
 tb/tb_count_schedule_ctrl.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/count_sched_pkg.sv
// Shared types for the shrinking-limit count scheduler.
// State encoding, default width and the latched config bundle.
package count_sched_pkg;

  localparam int CS_WIDTH = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_STEP = 2'd2,
    S_DONE = 2'd3
  } state_e;

  typedef struct packed {
    logic [CS_WIDTH-1:0] start_lim;
    logic [CS_WIDTH-1:0] step;
    logic [CS_WIDTH-1:0] floor;
    logic                loop;
  } cfg_t;

endpackage

// File: rtl/limit_counter.sv
// Round counter: counts 0..limit, flags the last count and
// restarts from zero on its own at the end of a round.
module limit_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] count,
  output logic             at_limit
);

  logic [WIDTH-1:0] r_count;

  assign count    = r_count;
  assign at_limit = (r_count == limit);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (enable) begin
      r_count <= at_limit ? '0 : r_count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/count_schedule_ctrl.sv
// Schedule controller: latches config on start, walks the limit
// down by step each round and finishes or reloads past the floor.
module count_schedule_ctrl
  import count_sched_pkg::*;
#(
  parameter int WIDTH = CS_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] cfg_start_lim,
  input  logic [WIDTH-1:0] cfg_step,
  input  logic [WIDTH-1:0] cfg_floor,
  input  logic             cfg_loop,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] cur_lim,
  output logic             busy,
  output logic             round_done,
  output logic             wrap,
  output logic             done,
  output logic             cfg_err
);

  state_e           r_state;
  state_e           w_state_nxt;
  cfg_t             r_cfg;
  logic [WIDTH-1:0] r_cur_lim;
  logic [WIDTH-1:0] w_lim_nxt;
  logic             r_cfg_err;
  logic             w_err;
  logic             w_load;
  logic             w_clear;
  logic             w_enable;
  logic             w_at_lim;
  logic             w_wrap;
  logic             w_done;
  logic             w_cfg_bad;
  logic             w_under;
  logic [WIDTH:0]   w_sub;

  assign w_cfg_bad = (cfg_step == '0) || (cfg_start_lim == '0)
                  || (cfg_floor > cfg_start_lim);

  // Extra bit catches underflow of cur_lim - step.
  assign w_sub   = {1'b0, r_cur_lim} - {1'b0, r_cfg.step};
  assign w_under = w_sub[WIDTH] || (w_sub[WIDTH-1:0] < r_cfg.floor);

  assign w_enable = (r_state == S_RUN) && !abort;

  limit_counter #(.WIDTH(WIDTH)) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .clear    (w_clear),
    .enable   (w_enable),
    .limit    (r_cur_lim),
    .count    (count),
    .at_limit (w_at_lim)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_cur_lim <= '0;
      r_cfg     <= '0;
      r_cfg_err <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cur_lim <= w_lim_nxt;
      r_cfg_err <= w_err;
      if (w_load) begin
        r_cfg.start_lim <= cfg_start_lim;
        r_cfg.step      <= cfg_step;
        r_cfg.floor     <= cfg_floor;
        r_cfg.loop      <= cfg_loop;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_lim_nxt   = r_cur_lim;
    w_clear     = 1'b0;
    w_load      = 1'b0;
    w_err       = 1'b0;
    w_wrap      = 1'b0;
    w_done      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          if (w_cfg_bad) begin
            w_err = 1'b1;
          end else begin
            w_load      = 1'b1;
            w_clear     = 1'b1;
            w_lim_nxt   = cfg_start_lim;
            w_state_nxt = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (abort) begin
          w_clear     = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (w_at_lim) begin
          w_state_nxt = S_STEP;
        end
      end
      S_STEP: begin
        if (abort) begin
          w_clear     = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (!w_under) begin
          w_lim_nxt   = w_sub[WIDTH-1:0];
          w_state_nxt = S_RUN;
        end else if (r_cfg.loop) begin
          w_lim_nxt   = r_cfg.start_lim;
          w_wrap      = 1'b1;
          w_state_nxt = S_RUN;
        end else begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_clear     = abort;
        w_done      = !abort;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign cur_lim    = r_cur_lim;
  assign busy       = (r_state != S_IDLE);
  assign round_done = (r_state == S_RUN) && w_at_lim && !abort;
  assign wrap       = w_wrap;
  assign done       = w_done;
  assign cfg_err    = r_cfg_err;

endmodule

// File: tb/tb_count_schedule_ctrl.sv
// Bench for count_schedule_ctrl: vector table, corner sequences and
// random schedules checked against a round-by-round schedule model.
module tb_count_schedule_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       cfg_loop = 1'b0;
  logic [3:0] cfg_start_lim = '0;
  logic [3:0] cfg_step = '0;
  logic [3:0] cfg_floor = '0;
  logic [3:0] count;
  logic [3:0] cur_lim;
  logic       busy;
  logic       round_done;
  logic       wrap;
  logic       done;
  logic       cfg_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  count_schedule_ctrl #(.WIDTH(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .abort         (abort),
    .cfg_start_lim (cfg_start_lim),
    .cfg_step      (cfg_step),
    .cfg_floor     (cfg_floor),
    .cfg_loop      (cfg_loop),
    .count         (count),
    .cur_lim       (cur_lim),
    .busy          (busy),
    .round_done    (round_done),
    .wrap          (wrap),
    .done          (done),
    .cfg_err       (cfg_err)
  );

  typedef struct {
    int cnt;
    int lim;
    int busy;
    int rd;
    int wr;
    int dn;
  } tr_t;

  typedef struct {
    int sl;
    int st;
    int fl;
    int lp;
    int err;
    int rds;
    int dn;
  } vec_t;

  tr_t  exp_q[$];
  vec_t vt[8];
  int   rd_seen;
  int   wr_seen;
  int   wr_first;
  int   dn_cyc;

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d", nm, act, exp);
    end
  endtask

  task automatic push(int c, int l, int b, int r, int w, int d);
    tr_t t;
    t.cnt = c; t.lim = l; t.busy = b;
    t.rd = r; t.wr = w; t.dn = d;
    exp_q.push_back(t);
  endtask

  // Expected per-cycle trace starting the cycle after the start edge.
  task automatic build(int sl, int st, int fl, int lp, int maxc);
    int lim;
    int nxt;
    exp_q.delete();
    lim = sl;
    while (exp_q.size() < maxc) begin
      for (int c = 0; c <= lim; c++)
        push(c, lim, 1, (c == lim) ? 1 : 0, 0, 0);
      nxt = lim - st;
      if (nxt < 0 || nxt < fl) begin
        if (lp != 0) begin
          push(0, lim, 1, 0, 1, 0);
          lim = sl;
        end else begin
          push(0, lim, 1, 0, 0, 0);
          push(0, lim, 1, 0, 0, 1);
          push(0, lim, 0, 0, 0, 0);
          break;
        end
      end else begin
        push(0, lim, 1, 0, 0, 0);
        lim = nxt;
      end
    end
  endtask

  // ab>0: abort held high during cycle ab. mid: random start/cfg while busy.
  task automatic run_sched(string tag, int sl, int st, int fl, int lp,
                           int ab, int mid);
    int  n;
    tr_t e;
    build(sl, st, fl, lp, (lp != 0) ? ab + 8 : 1000);
    n = (ab > 0) ? ab + 2 : exp_q.size();
    rd_seen = 0; wr_seen = 0; wr_first = -1; dn_cyc = -1;
    @(posedge clk); #1;
    start = 1'b1;
    abort = mid ? 1'($urandom_range(0, 1)) : 1'b0;
    cfg_start_lim = 4'(sl); cfg_step = 4'(st);
    cfg_floor = 4'(fl); cfg_loop = 1'(lp);
    @(negedge clk);
    chk($sformatf("%s_idle_busy", tag), busy, 0);
    for (int i = 1; i <= n; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
      abort = (i == ab);
      if (mid != 0) begin
        cfg_start_lim = 4'($urandom); cfg_step = 4'($urandom);
        cfg_floor = 4'($urandom); cfg_loop = 1'($urandom);
        if (exp_q[i-1].busy == 1 && (ab <= 0 || i <= ab))
          start = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      if (ab <= 0 || i < ab) begin
        e = exp_q[i-1];
      end else if (i == ab) begin
        e = exp_q[i-1];
        e.rd = 0; e.wr = 0; e.dn = 0;
      end else begin
        e.cnt = 0; e.lim = exp_q[ab-1].lim; e.busy = 0;
        e.rd = 0; e.wr = 0; e.dn = 0;
      end
      chk($sformatf("%s_count@%0d", tag, i), count, e.cnt);
      chk($sformatf("%s_cur_lim@%0d", tag, i), cur_lim, e.lim);
      chk($sformatf("%s_busy@%0d", tag, i), busy, e.busy);
      chk($sformatf("%s_round_done@%0d", tag, i), round_done, e.rd);
      chk($sformatf("%s_wrap@%0d", tag, i), wrap, e.wr);
      chk($sformatf("%s_done@%0d", tag, i), done, e.dn);
      chk($sformatf("%s_cfg_err@%0d", tag, i), cfg_err, 0);
      if (round_done) rd_seen++;
      if (wrap) begin
        wr_seen++;
        if (wr_first < 0) wr_first = i;
      end
      if (done) dn_cyc = i;
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic run_err(string tag, int sl, int st, int fl);
    @(posedge clk); #1;
    start = 1'b1;
    abort = 1'($urandom_range(0, 1));
    cfg_start_lim = 4'(sl); cfg_step = 4'(st);
    cfg_floor = 4'(fl); cfg_loop = 1'($urandom);
    @(negedge clk);
    chk({tag, "_err_early"}, cfg_err, 0);
    @(posedge clk); #1;
    start = 1'b0;
    abort = 1'b0;
    @(negedge clk);
    chk({tag, "_err_pulse"}, cfg_err, 1);
    chk({tag, "_err_busy"}, busy, 0);
    chk({tag, "_err_count"}, count, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk({tag, "_err_once"}, cfg_err, 0);
    chk({tag, "_err_busy2"}, busy, 0);
  endtask

  initial begin
    int sl, st, fl, lp, ab, mid;

    vt[0] = '{15, 1, 13, 0, 0, 3, 49};
    vt[1] = '{ 3, 2,  0, 0, 0, 2,  9};
    vt[2] = '{ 5, 5,  0, 0, 0, 2, 10};
    vt[3] = '{ 1, 1,  1, 0, 0, 1,  4};
    vt[4] = '{15,15,  0, 0, 0, 2, 20};
    vt[5] = '{ 0, 1,  0, 0, 1, 0, -1};
    vt[6] = '{ 4, 0,  0, 0, 1, 0, -1};
    vt[7] = '{ 4, 1,  5, 0, 1, 0, -1};

    #12;
    chk("rst_count", count, 0);
    chk("rst_cur_lim", cur_lim, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pulses", {29'd0, round_done, wrap, done}, 0);
    chk("rst_cfg_err", cfg_err, 0);
    @(posedge clk); #1;
    rst = 1'b1;

    for (int v = 0; v < 8; v++) begin
      if (vt[v].err != 0) begin
        run_err($sformatf("vec%0d", v), vt[v].sl, vt[v].st, vt[v].fl);
      end else begin
        run_sched($sformatf("vec%0d", v), vt[v].sl, vt[v].st,
                  vt[v].fl, vt[v].lp, -1, 0);
        chk($sformatf("vec%0d_rounds", v), rd_seen, vt[v].rds);
        chk($sformatf("vec%0d_done_cycle", v), dn_cyc, vt[v].dn);
        chk($sformatf("vec%0d_wraps", v), wr_seen, 0);
      end
    end

    run_sched("loop_long", 2, 1, 1, 1, 40, 0);
    chk("loop_wraps", wr_seen, 5);
    chk("loop_first_wrap", wr_first, 7);
    chk("loop_no_done", dn_cyc, -1);

    run_sched("loop_abort_r3", 2, 1, 1, 1, 9, 0);
    chk("abort_r3_no_done", dn_cyc, -1);

    run_sched("abort_at_lim", 2, 1, 1, 1, 3, 0);
    chk("abort_at_lim_no_rd", rd_seen, 0);

    run_sched("mid_start", 15, 1, 13, 0, -1, 1);
    chk("mid_start_done_cycle", dn_cyc, 49);

    @(posedge clk); #1;
    start = 1'b1;
    cfg_start_lim = 4'd15; cfg_step = 4'd1;
    cfg_floor = 4'd13; cfg_loop = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    chk("pre_rst_busy", busy, 1);
    rst = 1'b0;
    #1;
    chk("async_rst_count", count, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_cur_lim", cur_lim, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("post_rst_busy%0d", i), busy, 0);
      chk($sformatf("post_rst_count%0d", i), count, 0);
    end

    for (int r = 0; r < 30; r++) begin
      sl  = $urandom_range(1, 15);
      st  = $urandom_range(1, 15);
      fl  = $urandom_range(0, sl);
      lp  = $urandom_range(0, 1);
      mid = $urandom_range(0, 1);
      if (lp != 0) begin
        ab = $urandom_range(1, 50);
      end else begin
        build(sl, st, fl, 0, 1000);
        ab = ($urandom_range(0, 1) != 0)
           ? $urandom_range(1, exp_q.size() - 1) : -1;
      end
      run_sched($sformatf("rnd%0d", r), sl, st, fl, lp, ab, mid);
    end

    for (int r = 0; r < 6; r++) begin
      sl = $urandom_range(1, 14);
      if (r % 2 == 0)
        run_err($sformatf("rnd_bad%0d", r), sl, 0, 0);
      else
        run_err($sformatf("rnd_bad%0d", r), sl, $urandom_range(1, 15),
                $urandom_range(sl + 1, 15));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
